// File: rtl/note_hit_scorer.sv
// note_hit_scorer: judges button presses against a hit window on pos,
// keeping a saturating score and combo plus judgement strobes.
module note_hit_scorer #(
    parameter logic [6:0]  HIT_LO      = 7'd90,
    parameter logic [6:0]  HIT_HI      = 7'd97,
    parameter logic [6:0]  PERFECT_POS = 7'd94,
    parameter logic [15:0] PTS_GOOD    = 16'd10,
    parameter logic [15:0] PTS_PERFECT = 16'd25,
    parameter logic [7:0]  COMBO_TH    = 8'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_en,
    input  logic        clr_score,
    input  logic [6:0]  pos,
    input  logic        hit_btn,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [1:0]  judge,
    output logic        hit_pulse,
    output logic        miss_pulse
);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        WINDOW = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        s1_q, s2_q, s3_q;
    logic [6:0]  pos_q;
    logic [15:0] score_q;
    logic [7:0]  combo_q;
    logic [1:0]  judge_q;
    logic        hit_pulse_q, miss_pulse_q;

    logic        rise, wrap, in_win, past, perfect;
    logic        do_hit, do_miss;
    logic [15:0] base_pts, pts, score_sat;
    logic [16:0] sum;
    logic [7:0]  combo_inc;
    state_t      reentry;

    assign rise    = s2_q & ~s3_q;
    assign wrap    = pos < pos_q;
    assign in_win  = (pos >= HIT_LO) && (pos <= HIT_HI);
    assign past    = pos > HIT_HI;
    assign perfect = pos == PERFECT_POS;
    assign reentry = in_win ? WINDOW : WAIT;

    assign base_pts  = perfect ? PTS_PERFECT : PTS_GOOD;
    assign pts       = (combo_q >= COMBO_TH) ? {base_pts[14:0], 1'b0} : base_pts;
    assign sum       = {1'b0, score_q} + {1'b0, pts};
    assign score_sat = sum[16] ? 16'hFFFF : sum[15:0];
    assign combo_inc = (&combo_q) ? combo_q : combo_q + 8'd1;

    // WAIT and WINDOW share one decision on pos range so an edge entering
    // the window is judged as in-window.
    always_comb begin
        state_d = state_q;
        do_hit  = 1'b0;
        do_miss = 1'b0;
        if (!game_en) begin
            state_d = WAIT;
        end else begin
            case (state_q)
                DONE: begin
                    if (wrap) state_d = reentry;
                end
                default: begin
                    if (wrap) begin
                        do_miss = 1'b1;
                        state_d = reentry;
                    end else if (past) begin
                        do_miss = 1'b1;
                        state_d = DONE;
                    end else if (in_win) begin
                        do_hit  = rise;
                        state_d = rise ? DONE : WINDOW;
                    end else begin
                        do_miss = rise;
                        state_d = WAIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            pos_q        <= '0;
            state_q      <= WAIT;
            score_q      <= '0;
            combo_q      <= '0;
            judge_q      <= 2'd0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            s1_q         <= hit_btn;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            pos_q        <= pos;
            state_q      <= state_d;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            if (clr_score) begin
                score_q <= '0;
                combo_q <= '0;
                judge_q <= 2'd0;
            end else if (do_hit) begin
                score_q     <= score_sat;
                combo_q     <= combo_inc;
                judge_q     <= perfect ? 2'd2 : 2'd1;
                hit_pulse_q <= 1'b1;
            end else if (do_miss) begin
                combo_q      <= '0;
                judge_q      <= 2'd3;
                miss_pulse_q <= 1'b1;
            end
        end
    end

    assign score      = score_q;
    assign combo      = combo_q;
    assign judge      = judge_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_note_hit_scorer.sv
// tb_note_hit_scorer: directed note ramps with a queued scoreboard
// checked by an independent pulse monitor.
module tb_note_hit_scorer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        game_en = 1'b1;
    logic        clr_score = 1'b0;
    logic [6:0]  pos = '0;
    logic        hit_btn = 1'b0;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [1:0]  judge;
    logic        hit_pulse;
    logic        miss_pulse;

    typedef struct {
        logic        hit;
        logic [1:0]  judge;
        logic [15:0] score;
        logic [7:0]  combo;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;

    note_hit_scorer dut (
        .clk        (clk),
        .rst        (rst),
        .game_en    (game_en),
        .clr_score  (clr_score),
        .pos        (pos),
        .hit_btn    (hit_btn),
        .score      (score),
        .combo      (combo),
        .judge      (judge),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && (hit_pulse || miss_pulse)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse act hit=%0b miss=%0b judge=%0d score=%0d combo=%0d exp none",
                         hit_pulse, miss_pulse, judge, score, combo);
            end else begin
                me = q.pop_front();
                if (hit_pulse !== me.hit || miss_pulse !== !me.hit ||
                    judge !== me.judge || score !== me.score || combo !== me.combo) begin
                    errors++;
                    $display("FAIL judgement act hit=%0b miss=%0b judge=%0d score=%0d combo=%0d exp hit=%0b judge=%0d score=%0d combo=%0d",
                             hit_pulse, miss_pulse, judge, score, combo,
                             me.hit, me.judge, me.score, me.combo);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic push(input bit hit, input int j, input int s, input int c);
        exp_t e;
        e.hit   = hit;
        e.judge = j[1:0];
        e.score = s[15:0];
        e.combo = c[7:0];
        q.push_back(e);
    endtask

    // Press decision lands on pos p: the button rises two steps earlier.
    task automatic run(input int lo, input int hi, input int p1, input int p2,
                       input int h, input int en_from);
        for (int v = lo; v <= hi; v++) begin
            @(negedge clk);
            pos     = v[6:0];
            game_en = (v >= en_from);
            hit_btn = (p1 >= 0 && v >= p1 - 2 && v < p1 - 2 + h) ||
                      (p2 >= 0 && v >= p2 - 2 && v < p2 - 2 + h);
        end
    endtask

    task automatic drain(input string name);
        repeat (2) @(negedge clk);
        #1;
        chk({name, "_leftover"}, q.size(), 0);
        q.delete();
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_score"}, int'(score), 0);
        chk({name, "_combo"}, int'(combo), 0);
        chk({name, "_judge"}, int'(judge), 0);
        chk({name, "_hit"}, int'(hit_pulse), 0);
        chk({name, "_miss"}, int'(miss_pulse), 0);
    endtask

    initial begin
        int escore;
        int ecombo;

        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Unpressed note: one miss as pos passes the window.
        push(0, 3, 0, 0);
        run(0, 99, -1, -1, 1, 0);
        drain("no_press");

        // Perfect hit, second press in the same note ignored.
        push(1, 2, 25, 1);
        run(0, 99, 94, 96, 1, 0);
        drain("perfect");

        @(negedge clk);
        clr_score = 1'b1;
        @(negedge clk);
        clr_score = 1'b0;
        #1;
        chk("clr_score", int'(score), 0);
        chk("clr_combo", int'(combo), 0);
        chk("clr_judge", int'(judge), 0);

        // Eleven good hits; the eleventh is doubled.
        for (int i = 0; i < 11; i++) begin
            push(1, 1, (i < 10) ? 10 * (i + 1) : 120, i + 1);
            run(0, 99, 92, -1, 1, 0);
        end
        drain("combo_run");

        // Early miss, then button held through the window.
        push(0, 3, 120, 0);
        push(0, 3, 120, 0);
        run(0, 99, 50, -1, 60, 0);
        drain("early_held");

        // Short notes of perfect hits until the score saturates.
        escore = 120;
        ecombo = 0;
        for (int i = 0; i < 1320; i++) begin
            escore += (ecombo >= 10) ? 50 : 25;
            if (escore > 65535) escore = 65535;
            ecombo = (ecombo < 255) ? ecombo + 1 : 255;
            push(1, 2, escore, ecombo);
            run(88, 98, 94, -1, 1, 0);
        end
        drain("saturate");
        chk("sat_score", int'(score), 65535);
        chk("sat_combo", int'(combo), 255);

        // Disabled across the press, re-enabled inside the window.
        push(0, 3, 65535, 0);
        run(0, 99, 94, -1, 1, 95);
        drain("game_en");

        // clr_score on the same edge as a valid rise.
        run(0, 93, 94, -1, 1, 0);
        @(negedge clk);
        pos       = 7'd94;
        hit_btn   = 1'b0;
        clr_score = 1'b1;
        @(negedge clk);
        clr_score = 1'b0;
        pos       = 7'd95;
        #1;
        chk("clr_rise_score", int'(score), 0);
        chk("clr_rise_combo", int'(combo), 0);
        chk("clr_rise_judge", int'(judge), 0);
        chk("clr_rise_hit", int'(hit_pulse), 0);

        @(negedge clk);
        rst = 1'b0;
        pos = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Async reset with a press in flight.
        push(1, 1, 10, 1);
        run(0, 99, 92, -1, 1, 0);
        drain("pre_reset");
        run(0, 93, 94, -1, 1, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        pos     = 7'd94;
        hit_btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push(0, 3, 0, 0);
        run(95, 99, -1, -1, 1, 0);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
